// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_responder                                                  |
// | Brief    : Multi-cycle MEM-stage data memory target with a fixed latency   |
// |            request/acknowledge handshake. Optional alignment check is      |
// |            enabled by defining DMEM_RESPONDER_ALIGN_CHECK_EN.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  output logic        busy_o,
  output logic        err_o
`else
  output logic        busy_o
`endif
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_we;
  logic [c_idx_w-1:0] r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_fire;
  logic               w_we;
  logic [c_idx_w-1:0] w_idx;
  logic [31:0]        w_wdata;
  logic               w_mis;
  logic               w_unused;

  assign w_accept = (r_state == c_idle) && req_i;

  // With LATENCY = 1 the access completes on its own acceptance edge, so the
  // live inputs are used instead of the (not yet loaded) latch registers.
  assign w_we    = (r_state == c_idle) ? we_i    : r_we;
  assign w_idx   = (r_state == c_idle) ? addr_i[c_idx_w+1:2] : r_idx;
  assign w_wdata = (r_state == c_idle) ? wdata_i : r_wdata;

  assign w_fire = !rst_i &&
                  ((w_accept && (LATENCY == 1)) ||
                   ((r_state == c_wait) && (r_cnt == c_cnt_w'(1))));

  assign w_unused = ^{addr_i[31:c_idx_w+2], addr_i[1:0]};

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  logic r_mis;
  assign w_mis = (r_state == c_idle) ? (addr_i[1:0] != 2'b00) : r_mis;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mis <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mis <= (addr_i[1:0] != 2'b00);
      end
      err_o <= w_fire && w_mis;
    end
  end
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      ack_o   <= 1'b0;
      busy_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o <= 1'b0;
      case (r_state)
        c_idle: begin
          if (req_i) begin
            r_we    <= we_i;
            r_idx   <= addr_i[c_idx_w+1:2];
            r_wdata <= wdata_i;
            r_cnt   <= c_cnt_w'(LATENCY - 1);
            busy_o  <= 1'b1;
            r_state <= (LATENCY == 1) ? c_resp : c_wait;
          end
        end
        c_wait: begin
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            r_state <= c_resp;
          end
        end
        c_resp: begin
          busy_o  <= 1'b0;
          r_state <= c_idle;
        end
        default: begin
          busy_o  <= 1'b0;
          r_state <= c_idle;
        end
      endcase

      if (w_fire) begin
        ack_o <= 1'b1;
        if (!w_we) begin
          rdata_o <= w_mis ? 32'h0 : r_mem[w_idx];
        end
      end
    end
  end

  // Backing array has no reset; a store commits on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (w_fire && w_we && !w_mis) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                               |
// | Brief    : Scoreboard bench for dmem_responder, LATENCY=2 and LATENCY=1.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int L0 = 2;
  localparam int L1 = 1;

  typedef struct packed {
    logic        ld;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic [31:0] rdata [2];
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  logic        err   [2];
`endif

  int total = 0;
  int bad   = 0;
  int extra [2];
  exp_t q0 [$];
  exp_t q1 [$];
  logic [31:0] mem_m   [2][32];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .LATENCY(L0)) u_dut0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req[0]),
    .we_i    (we[0]),
    .addr_i  (addr[0]),
    .wdata_i (wdata[0]),
    .ack_o   (ack[0]),
    .rdata_o (rdata[0]),
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    .err_o   (err[0]),
`endif
    .busy_o  (busy[0])
  );

  dmem_responder #(.DEPTH(32), .LATENCY(L1)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req[1]),
    .we_i    (we[1]),
    .addr_i  (addr[1]),
    .wdata_i (wdata[1]),
    .ack_o   (ack[1]),
    .rdata_o (rdata[1]),
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    .err_o   (err[1]),
`endif
    .busy_o  (busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  task automatic push_exp(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic mis;
    int   idx;
    idx = int'(a[6:2]);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    e.e  = mis;
    e.ld = !w;
    if (w) begin
      if (!mis) mem_m[d][idx] = wd;
      e.d = last_rd[d];
    end else begin
      e.d = mis ? 32'h0 : mem_m[d][idx];
      last_rd[d] = e.d;
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Scoreboard: every ack pops one expected response.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : g_mon
      exp_t e;
      if (ack[d] === 1'b1) begin
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          extra[d]++;
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check(e.ld ? "ld_data" : "st_hold", rdata[d], e.d);
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
          check("err_flag", {31'b0, err[d]}, {31'b0, e.e});
`endif
        end
      end
    end
  end

  task automatic acc(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    int n  = 0;
    int nb = 0;
    bit got = 1'b0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    push_exp(d, w, a, wd);
    @(posedge clk);
    #1 req[d] = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (busy[d]) nb++;
      if (ack[d]) got = 1'b1;
    end
    check({tag, "_lat"}, n, lat_of(d));
    check({tag, "_busy"}, nb, lat_of(d));
    @(negedge clk);
    check({tag, "_idle"}, {30'b0, busy[d], ack[d]}, 32'h0);
  endtask

  initial begin
    int nack;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      last_rd[d] = '0; extra[d] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_ack0",   {31'b0, ack[0]},  32'h0);
    check("rst_busy0",  {31'b0, busy[0]}, 32'h0);
    check("rst_rdata0", rdata[0], 32'h0);
    check("rst_ack1",   {31'b0, ack[1]},  32'h0);
    check("rst_rdata1", rdata[1], 32'h0);
    rst = 1'b0;

    // store then load
    acc(0, 1'b1, 32'h8, 32'h12345678, "st8");
    acc(0, 1'b0, 32'h8, 32'h0, "ld8");

    // wrap-around modulo DEPTH*4
    acc(0, 1'b1, 32'h84, 32'hA5A5A5A5, "st84");
    acc(0, 1'b0, 32'h04, 32'h0, "ld04");

`ifndef DMEM_RESPONDER_ALIGN_CHECK_EN
    acc(0, 1'b1, 32'h0B, 32'hCAFE0001, "st0b");
    acc(0, 1'b0, 32'h08, 32'h0, "ld08b");
`endif

    // reset in the middle of a store
    acc(0, 1'b1, 32'h10, 32'h11111111, "pre10");
    acc(0, 1'b0, 32'h10, 32'h0, "ld10a");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    check("rst_wait_busy", {31'b0, busy[0]}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_ack",   {31'b0, ack[0]},  32'h0);
    check("rst_mid_busy",  {31'b0, busy[0]}, 32'h0);
    check("rst_mid_rdata", rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    acc(0, 1'b0, 32'h10, 32'h0, "ld10b");

    // request traffic during WAIT is ignored
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h8; wdata[0] = 32'h0;
    push_exp(0, 1'b0, 32'h8, 32'h0);
    @(posedge clk);
    #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'hBAD0BAD0;
    @(posedge clk);
    #1 req[0] = 1'b0;
    nack = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack[0]) nack++;
    end
    check("ign_acks", nack, 1);
    acc(0, 1'b0, 32'h4, 32'h0, "ld04c");

    // LATENCY=1 back-to-back with req held high
    acc(1, 1'b1, 32'h0, 32'h01010101, "s1a");
    acc(1, 1'b1, 32'h4, 32'h02020202, "s1b");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    push_exp(1, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 addr[1] = 32'h4;
    push_exp(1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    check("b2b_ack_a", {31'b0, ack[1]}, 32'h1);
    @(negedge clk);
    check("b2b_gap",   {31'b0, ack[1]}, 32'h0);
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    check("b2b_ack_b", {31'b0, ack[1]}, 32'h1);
    @(negedge clk);
    check("b2b_end",   {31'b0, ack[1]}, 32'h0);

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    acc(0, 1'b1, 32'h08, 32'h00005555, "st08");
    acc(0, 1'b1, 32'h0A, 32'hFFFFFFFF, "st0a");
    acc(0, 1'b0, 32'h08, 32'h0, "ld08");
    acc(0, 1'b0, 32'h09, 32'h0, "ld09");
`endif

    repeat (2) @(negedge clk);
    check("extra_ack0", extra[0], 0);
    check("extra_ack1", extra[1], 0);
    check("pending0", q0.size(), 0);
    check("pending1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
